// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the FT245 receive path.
// The key constants are also used by the transmit framer.
package usb_rx_pkg;

    localparam logic [7:0] HDR_KEY     = 8'd85;
    localparam int         HDR_KEY_NUM = 12;
    localparam logic [7:0] TRL_KEY     = 8'd170;
    localparam int         TRL_KEY_NUM = 8;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        TRAILER,
        RELEASE
    } rx_state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_BAD_TRAILER,
        ERR_TIMEOUT,
        ERR_RSVD
    } rx_err_e;

endpackage

// File: rtl/ft_rd_if.sv
// FT245 read-strobe engine.
// Synchronizes RXF#, times the RD# low pulse and allows one byte per RXF# low period.
module ft_rd_if #(
    parameter int RD_LOW_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxf_n,
    input  logic [7:0] data_in,
    input  logic       rd_enable,
    output logic       rd_n,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    localparam int             CW       = $clog2(RD_LOW_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(RD_LOW_CYCLES - 1);

    logic          rxf_meta;
    logic          rxf_sync;
    logic          rearm;
    logic [CW-1:0] low_cnt;

    // Two-flop synchronizer; idles high so nothing is read out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxf_meta <= 1'b1;
            rxf_sync <= 1'b1;
        end else begin
            rxf_meta <= rxf_n;
            rxf_sync <= rxf_meta;
        end
    end

    // RD# pulse: start on armed RXF# low, sample on the last low clock, rearm on RXF# high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_n       <= 1'b1;
            rearm      <= 1'b1;
            low_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
        end else begin
            byte_valid <= 1'b0;
            if (rd_n) begin
                if (rxf_sync) begin
                    rearm <= 1'b1;
                end else if (rd_enable && rearm) begin
                    rd_n    <= 1'b0;
                    low_cnt <= '0;
                end
            end else if (low_cnt == CNT_LAST) begin
                byte_data  <= data_in;
                byte_valid <= 1'b1;
                rd_n       <= 1'b1;
                rearm      <= 1'b0;
            end else begin
                low_cnt <= low_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ft_rx_packet_parser.sv
// FT245 receive packet parser: header hunt, payload buffering, trailer check,
// and release of complete packets as 32-bit little-endian words.
module ft_rx_packet_parser #(
    parameter logic [7:0] HEADER_KEY_SYMBOL         = usb_rx_pkg::HDR_KEY,
    parameter int         HEADER_KEY_SYMBOL_NUMBER  = usb_rx_pkg::HDR_KEY_NUM,
    parameter logic [7:0] TRAILER_KEY_SYMBOL        = usb_rx_pkg::TRL_KEY,
    parameter int         TRAILER_KEY_SYMBOL_NUMBER = usb_rx_pkg::TRL_KEY_NUM,
    parameter int         PAYLOAD_BYTES             = 12,
    parameter int         RD_LOW_CYCLES             = 3,
    parameter int         BYTE_TIMEOUT              = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        FT_RXFn,
    input  logic [7:0]  FT_DATA_In,
    output logic        FT_RDn,
    output logic [31:0] Pkt_Data,
    output logic        Pkt_Valid,
    input  logic        Pkt_Ready,
    output logic        Pkt_Last,
    output logic        Header_recognized,
    output logic        Trailer_recognized,
    output logic        Error,
    output logic [1:0]  Error_Code
);
    import usb_rx_pkg::*;

    localparam int NW  = PAYLOAD_BYTES / 4;
    localparam int HW  = $clog2(HEADER_KEY_SYMBOL_NUMBER + 1);
    localparam int TW  = $clog2(TRAILER_KEY_SYMBOL_NUMBER + 1);
    localparam int BW  = $clog2(PAYLOAD_BYTES + 1);
    localparam int WW  = $clog2(NW + 1);
    localparam int TOW = $clog2(BYTE_TIMEOUT + 1);

    localparam logic [HW-1:0]  HDR_LAST = HW'(HEADER_KEY_SYMBOL_NUMBER - 1);
    localparam logic [TW-1:0]  TRL_LAST = TW'(TRAILER_KEY_SYMBOL_NUMBER - 1);
    localparam logic [BW-1:0]  PL_LAST  = BW'(PAYLOAD_BYTES - 1);
    localparam logic [WW-1:0]  W_LAST   = WW'(NW - 1);
    localparam logic [TOW-1:0] TO_LAST  = TOW'(BYTE_TIMEOUT - 1);

    rx_state_e      state;
    logic [HW-1:0]  hdr_cnt;
    logic [TW-1:0]  trl_cnt;
    logic [BW-1:0]  pl_cnt;
    logic [TOW-1:0] tmo_cnt;
    logic [WW-1:0]  widx;
    logic [7:0]     pbuf [PAYLOAD_BYTES];
    logic [1:0]     err_code;

    logic           byte_valid;
    logic [7:0]     byte_data;
    logic [WW-1:0]  nxt_widx;
    logic [31:0]    nxt_word;

    assign Error_Code = err_code;

    ft_rd_if #(
        .RD_LOW_CYCLES (RD_LOW_CYCLES)
    ) u_rd_if (
        .clk        (clk),
        .reset      (reset),
        .rxf_n      (FT_RXFn),
        .data_in    (FT_DATA_In),
        .rd_enable  (state != RELEASE),
        .rd_n       (FT_RDn),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    // Word to present next: word 0 on entry to RELEASE, else the one after the current
    always_comb begin
        int base;
        nxt_widx = Pkt_Valid ? widx + 1'b1 : '0;
        base     = (nxt_widx >= WW'(NW)) ? 0 : 4 * int'(nxt_widx);
        nxt_word = '0;
        for (int b = 0; b < 4; b++) begin
            nxt_word[8*b +: 8] = pbuf[base + b];
        end
    end

    // Framing FSM with registered pulses, word output and inter-byte timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= HUNT;
            hdr_cnt            <= '0;
            trl_cnt            <= '0;
            pl_cnt             <= '0;
            tmo_cnt            <= '0;
            widx               <= '0;
            err_code           <= ERR_NONE;
            Pkt_Data           <= '0;
            Pkt_Valid          <= 1'b0;
            Pkt_Last           <= 1'b0;
            Header_recognized  <= 1'b0;
            Trailer_recognized <= 1'b0;
            Error              <= 1'b0;
            for (int i = 0; i < PAYLOAD_BYTES; i++) pbuf[i] <= '0;
        end else begin
            Header_recognized  <= 1'b0;
            Trailer_recognized <= 1'b0;
            Error              <= 1'b0;
            case (state)
                HUNT: begin
                    if (byte_valid) begin
                        if (byte_data != HEADER_KEY_SYMBOL) begin
                            hdr_cnt <= '0;
                        end else if (hdr_cnt == HDR_LAST) begin
                            hdr_cnt           <= '0;
                            pl_cnt            <= '0;
                            tmo_cnt           <= '0;
                            Header_recognized <= 1'b1;
                            state             <= PAYLOAD;
                        end else begin
                            hdr_cnt <= hdr_cnt + 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (byte_valid) begin
                        tmo_cnt           <= '0;
                        pbuf[int'(pl_cnt)] <= byte_data;
                        if (pl_cnt == PL_LAST) begin
                            trl_cnt <= '0;
                            state   <= TRAILER;
                        end else begin
                            pl_cnt <= pl_cnt + 1'b1;
                        end
                    end else if (tmo_cnt == TO_LAST) begin
                        Error    <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= HUNT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                TRAILER: begin
                    if (byte_valid) begin
                        tmo_cnt <= '0;
                        if (byte_data != TRAILER_KEY_SYMBOL) begin
                            Error    <= 1'b1;
                            err_code <= ERR_BAD_TRAILER;
                            state    <= HUNT;
                        end else if (trl_cnt == TRL_LAST) begin
                            Trailer_recognized <= 1'b1;
                            state              <= RELEASE;
                        end else begin
                            trl_cnt <= trl_cnt + 1'b1;
                        end
                    end else if (tmo_cnt == TO_LAST) begin
                        Error    <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= HUNT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!Pkt_Valid) begin
                        Pkt_Valid <= 1'b1;
                        Pkt_Data  <= nxt_word;
                        Pkt_Last  <= (nxt_widx == W_LAST);
                        widx      <= nxt_widx;
                    end else if (Pkt_Ready) begin
                        if (Pkt_Last) begin
                            Pkt_Valid <= 1'b0;
                            Pkt_Last  <= 1'b0;
                            state     <= HUNT;
                        end else begin
                            Pkt_Data <= nxt_word;
                            Pkt_Last <= (nxt_widx == W_LAST);
                            widx     <= nxt_widx;
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_ft_rx_packet_parser.sv
// Self-checking bench: FT245 chip model feeding bytes, scoreboard of expected words.
module tb_ft_rx_packet_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic        FT_RXFn;
    logic [7:0]  FT_DATA_In;
    logic        FT_RDn;
    logic [31:0] Pkt_Data;
    logic        Pkt_Valid;
    logic        Pkt_Ready;
    logic        Pkt_Last;
    logic        Header_recognized;
    logic        Trailer_recognized;
    logic        Error;
    logic [1:0]  Error_Code;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] chip_q [$];
    bit         chip_busy = 0;
    int         errors = 0;
    int         checks = 0;
    int         hdr_n = 0, trl_n = 0, err_n = 0;

    always #5 clk = ~clk;

    ft_rx_packet_parser dut (
        .clk                (clk),
        .reset              (reset),
        .FT_RXFn            (FT_RXFn),
        .FT_DATA_In         (FT_DATA_In),
        .FT_RDn             (FT_RDn),
        .Pkt_Data           (Pkt_Data),
        .Pkt_Valid          (Pkt_Valid),
        .Pkt_Ready          (Pkt_Ready),
        .Pkt_Last           (Pkt_Last),
        .Header_recognized  (Header_recognized),
        .Trailer_recognized (Trailer_recognized),
        .Error              (Error),
        .Error_Code         (Error_Code)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // FT chip: present a byte with RXF# low, drop RXF# after RD# rises
    always begin
        logic [7:0] b;
        int n;
        @(posedge clk);
        if (chip_q.size() > 0) begin
            chip_busy = 1;
            b = chip_q.pop_front();
            #1;
            FT_DATA_In = b;
            FT_RXFn = 1'b0;
            n = 0;
            while (FT_RDn !== 1'b0 && n < 5000) begin @(posedge clk); n++; end
            if (n >= 5000) chk("rd_start_timeout", 0, 1);
            n = 0;
            while (FT_RDn === 1'b0 && n < 100) begin @(posedge clk); n++; end
            if (n >= 100) chk("rd_stuck_low", 0, 1);
            FT_RXFn = 1'b1;
            repeat (3) @(posedge clk);
            chip_busy = 0;
        end
    end

    // Pulse counters and scoreboard compare on accepted words
    always @(negedge clk) begin
        if (!reset) begin
            if (Header_recognized)  hdr_n++;
            if (Trailer_recognized) trl_n++;
            if (Error)              err_n++;
            if (Pkt_Valid && Pkt_Ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word", Pkt_Data, e.d);
                    chk("last", {31'd0, Pkt_Last}, {31'd0, e.l});
                end
            end
        end
    end

    task automatic push_rep(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) chip_q.push_back(b);
    endtask

    task automatic push_bytes(input logic [7:0] pl [12], input int from);
        for (int i = from; i < 12; i++) chip_q.push_back(pl[i]);
    endtask

    task automatic push_expect(input logic [7:0] pl [12]);
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.d = {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]};
            e.l = (k == 2);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_good(input logic [7:0] pl [12]);
        push_rep(8'h55, 12);
        push_bytes(pl, 0);
        push_rep(8'hAA, 8);
        push_expect(pl);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 Pkt_Ready = r;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((chip_q.size() != 0 || chip_busy || exp_q.size() != 0 || Pkt_Valid) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) chk("drain_timeout", 0, 1);
        repeat (5) @(posedge clk);
    endtask

    task automatic chk_pulses(input string tag, input int h0, input int t0, input int e0,
                              input int dh, input int dt, input int de);
        chk({tag, "_hdr"}, hdr_n - h0, dh);
        chk({tag, "_trl"}, trl_n - t0, dt);
        chk({tag, "_err"}, err_n - e0, de);
    endtask

    initial begin
        logic [7:0] nom   [12];
        logic [7:0] noise [12];
        logic [7:0] p2    [12];
        int h0, t0, e0, n;

        nom   = '{8'h14, 8'h00, 8'hCD, 8'hAB, 8'h0F, 8'hF0, 8'h34, 8'h56, 8'h09, 8'h10, 8'h11, 8'h12};
        noise = '{8'h55, 8'h55, 8'hCD, 8'hAB, 8'h0F, 8'hF0, 8'h34, 8'h56, 8'h09, 8'h10, 8'h11, 8'h12};
        p2    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'h55, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'hC3, 8'h3C};

        reset = 1'b1;
        FT_RXFn = 1'b1;
        FT_DATA_In = 8'h00;
        Pkt_Ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdn",   {31'd0, FT_RDn},    32'd1);
        chk("rst_valid", {31'd0, Pkt_Valid}, 32'd0);
        chk("rst_last",  {31'd0, Pkt_Last},  32'd0);
        chk("rst_data",  Pkt_Data,           32'd0);
        chk("rst_code",  {30'd0, Error_Code}, 32'd0);
        reset = 1'b0;

        // Nominal packet
        h0 = hdr_n; t0 = trl_n; e0 = err_n;
        send_good(nom);
        wait_idle(3000);
        chk_pulses("nominal", h0, t0, e0, 1, 1, 0);

        // Noise, broken key run, then extra keys rolling into payload
        h0 = hdr_n; t0 = trl_n; e0 = err_n;
        push_rep(8'h55, 3);
        push_rep(8'h00, 1);
        push_rep(8'h55, 14);
        push_bytes(noise, 2);
        push_rep(8'hAA, 8);
        push_expect(noise);
        wait_idle(3000);
        chk_pulses("noise", h0, t0, e0, 1, 1, 0);

        // Bad trailer discarded, next packet delivered
        h0 = hdr_n; t0 = trl_n; e0 = err_n;
        push_rep(8'h55, 12);
        push_bytes(p2, 0);
        push_rep(8'hAA, 7);
        push_rep(8'h00, 1);
        wait_idle(3000);
        chk_pulses("badtrl", h0, t0, e0, 1, 0, 1);
        chk("badtrl_code", {30'd0, Error_Code}, 32'd1);
        send_good(p2);
        wait_idle(3000);
        chk("badtrl_code_hold", {30'd0, Error_Code}, 32'd1);

        // Backpressure: hold Ready low with the next packet waiting at the chip
        h0 = hdr_n; t0 = trl_n; e0 = err_n;
        set_ready(1'b0);
        send_good(nom);
        send_good(p2);
        n = 0;
        while (!Pkt_Valid && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) chk("bp_valid_timeout", 0, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_data", Pkt_Data, 32'hABCD0014);
            chk("bp_rdn", {31'd0, FT_RDn}, 32'd1);
        end
        chk("bp_rxf_low", {31'd0, FT_RXFn}, 32'd0);
        set_ready(1'b1);
        wait_idle(5000);
        chk_pulses("bp", h0, t0, e0, 2, 2, 0);

        // Timeout after 5 payload bytes, then recovery
        h0 = hdr_n; t0 = trl_n; e0 = err_n;
        push_rep(8'h55, 12);
        for (int i = 0; i < 5; i++) chip_q.push_back(nom[i]);
        wait_idle(3000);
        repeat (1100) @(posedge clk);
        chk_pulses("tmo", h0, t0, e0, 1, 0, 1);
        chk("tmo_code", {30'd0, Error_Code}, 32'd2);
        send_good(p2);
        wait_idle(3000);
        chk("tmo_code_hold", {30'd0, Error_Code}, 32'd2);

        // Reset while RD# is low
        push_rep(8'h55, 12);
        for (int i = 0; i < 3; i++) chip_q.push_back(nom[i]);
        n = 0;
        while (!(chip_q.size() == 0 && FT_RDn === 1'b0) && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 3000) chk("rst_mid_timeout", 0, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_rdn",   {31'd0, FT_RDn},    32'd1);
        chk("rst_mid_valid", {31'd0, Pkt_Valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_mid_code", {30'd0, Error_Code}, 32'd0);
        wait_idle(500);
        h0 = hdr_n; t0 = trl_n; e0 = err_n;
        send_good(nom);
        wait_idle(3000);
        chk_pulses("post_rst", h0, t0, e0, 1, 1, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
